// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: 40x30 one-bit playfield. Two write requesters share the
// back buffer through round-robin arbitration, a row-sequenced engine clears it,
// and the back buffer is copied to the displayed front buffer on vblank rise.
module framebuffer_arbiter #(
   parameter int COLS = 40,
   parameter int ROWS = 30
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 vblank,
   input  logic                 clear_req,
   input  logic                 req_a,
   input  logic [5:0]           x_a,
   input  logic [4:0]           y_a,
   input  logic                 val_a,
   output logic                 gnt_a,
   input  logic                 req_b,
   input  logic [5:0]           x_b,
   input  logic [4:0]           y_b,
   input  logic                 val_b,
   output logic                 gnt_b,
   output logic                 busy,
   output logic                 drop,
   output logic                 frame_done,
   output logic [COLS*ROWS-1:0] framebuffer
);

   localparam int NBITS = COLS * ROWS;
   localparam int IW    = $clog2(NBITS);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [5:0]    COLS_X    = 6'(COLS);
   localparam logic [4:0]    ROWS_Y    = 5'(ROWS);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

   typedef enum logic [0:0] {ST_RUN, ST_CLEAR} state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    row_q, row_d;
   logic             commit_pend_q, commit_pend_d;
   logic             last_b_q, last_b_d;      // 1: B was granted last
   logic             vblank_q, vblank_d;
   logic             drop_q, drop_d;
   logic             frame_done_q, frame_done_d;
   logic [NBITS-1:0] back_q, back_d;
   logic [NBITS-1:0] front_q, front_d;

   logic             vblank_rise, commit_go, run_free;
   logic             gnt_a_c, gnt_b_c;
   logic [5:0]       wr_x;
   logic [4:0]       wr_y;
   logic             wr_val, wr_in_range;
   logic [IW-1:0]    wr_idx, row_base;

   // Grants are only offered when RUN has nothing more urgent; reset_n gates
   // them so they read 0 while reset is held.
   always_comb begin
      vblank_rise = vblank & ~vblank_q;
      commit_go   = vblank_rise | commit_pend_q;
      run_free    = reset_n & (state_q == ST_RUN) & ~commit_go & ~clear_req;
      gnt_a_c     = run_free & req_a & (~req_b | last_b_q);
      gnt_b_c     = run_free & req_b & (~req_a | ~last_b_q);
      wr_x        = gnt_b_c ? x_b   : x_a;
      wr_y        = gnt_b_c ? y_b   : y_a;
      wr_val      = gnt_b_c ? val_b : val_a;
      wr_in_range = (wr_x < COLS_X) & (wr_y < ROWS_Y);
      wr_idx      = IW'(wr_y) * IW'(COLS) + IW'(wr_x);
      row_base    = IW'(row_q) * IW'(COLS);
   end

   // Next-state: commit beats clear beats writes in RUN; CLEAR wipes one row
   // per cycle and remembers a vblank rise for the first RUN cycle.
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      commit_pend_d = commit_pend_q;
      last_b_d      = last_b_q;
      vblank_d      = vblank;
      drop_d        = 1'b0;
      frame_done_d  = 1'b0;
      back_d        = back_q;
      front_d       = front_q;
      case (state_q)
         ST_RUN: begin
            if (commit_go) begin
               front_d       = back_q;
               commit_pend_d = 1'b0;
               frame_done_d  = 1'b1;
            end else if (clear_req) begin
               state_d = ST_CLEAR;
               row_d   = '0;
            end else if (gnt_a_c | gnt_b_c) begin
               last_b_d = gnt_b_c;
               if (wr_in_range) back_d[wr_idx] = wr_val;
               else             drop_d         = 1'b1;
            end
         end
         ST_CLEAR: begin
            back_d[row_base +: COLS] = '0;
            if (vblank_rise) commit_pend_d = 1'b1;
            if (row_q == LAST_ROW) begin
               state_d = ST_RUN;
               row_d   = '0;
            end else begin
               row_d = row_q + RW'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State registers; vblank_q resets high so reset release never commits.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         row_q         <= '0;
         commit_pend_q <= 1'b0;
         last_b_q      <= 1'b1;
         vblank_q      <= 1'b1;
         drop_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         back_q        <= '0;
         front_q       <= '0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         commit_pend_q <= commit_pend_d;
         last_b_q      <= last_b_d;
         vblank_q      <= vblank_d;
         drop_q        <= drop_d;
         frame_done_q  <= frame_done_d;
         back_q        <= back_d;
         front_q       <= front_d;
      end
   end

   assign gnt_a       = gnt_a_c;
   assign gnt_b       = gnt_b_c;
   assign busy        = (state_q == ST_CLEAR);
   assign drop        = drop_q;
   assign frame_done  = frame_done_q;
   assign framebuffer = front_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: directed scenarios plus a random phase, all
// checked every cycle against a behavioural model of the playfield.
module tb_framebuffer_arbiter;
   localparam int COLS = 40;
   localparam int ROWS = 30;
   localparam int N    = COLS * ROWS;

   logic         clk = 1'b0, rst_n = 1'b0, vblank = 1'b0, clear_req = 1'b0;
   logic         req_a = 1'b0, val_a = 1'b0, req_b = 1'b0, val_b = 1'b0;
   logic [5:0]   x_a = '0, x_b = '0;
   logic [4:0]   y_a = '0, y_b = '0;
   logic         gnt_a, gnt_b, busy, drop, frame_done;
   logic [N-1:0] framebuffer;

   framebuffer_arbiter #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clock(clk), .reset_n(rst_n), .vblank(vblank), .clear_req(clear_req),
      .req_a(req_a), .x_a(x_a), .y_a(y_a), .val_a(val_a), .gnt_a(gnt_a),
      .req_b(req_b), .x_b(x_b), .y_b(y_b), .val_b(val_b), .gnt_b(gnt_b),
      .busy(busy), .drop(drop), .frame_done(frame_done), .framebuffer(framebuffer)
   );

   always #10 clk = ~clk;

   // behavioural model of the playfield
   logic [N-1:0] m_back, m_front;
   bit m_vb_prev, m_pend, m_last_a, e_ga, e_gb, e_drop, e_fd;
   int m_clear_left;
   int n_pass = 0, n_total = 0;
   logic obs_ga, obs_gb, obs_busy, obs_drop, obs_fd;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %b, want %b", tag, obs, exp);
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs == exp) n_pass++;
      else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   task automatic chk_fb(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      int first;
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         first = -1;
         for (int i = N - 1; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
         $error("FAIL %s: framebuffer bit %0d got %b, want %b", tag, first,
                obs[first], exp[first]);
      end
   endtask

   function automatic void model_reset();
      m_back = '0; m_front = '0; m_vb_prev = 1'b1; m_pend = 1'b0;
      m_clear_left = 0; m_last_a = 1'b0; e_drop = 1'b0; e_fd = 1'b0;
      e_ga = 1'b0; e_gb = 1'b0;
   endfunction

   // who should be granted this cycle, from the current inputs
   function automatic void model_grants();
      bit rise;
      rise = vblank && !m_vb_prev;
      e_ga = 1'b0; e_gb = 1'b0;
      if (m_clear_left == 0 && !(rise || m_pend) && !clear_req) begin
         if (req_a && req_b) begin
            if (m_last_a) e_gb = 1'b1; else e_ga = 1'b1;
         end else begin
            e_ga = req_a; e_gb = req_b;
         end
      end
   endfunction

   // what the clock edge does to the playfield
   function automatic void model_edge();
      bit rise;
      int row, x, y;
      rise = vblank && !m_vb_prev;
      e_drop = 1'b0; e_fd = 1'b0;
      if (m_clear_left > 0) begin
         row = ROWS - m_clear_left;
         for (int c = 0; c < COLS; c++) m_back[row*COLS + c] = 1'b0;
         m_clear_left--;
         if (rise) m_pend = 1'b1;
      end else if (rise || m_pend) begin
         m_front = m_back; m_pend = 1'b0; e_fd = 1'b1;
      end else if (clear_req) begin
         m_clear_left = ROWS;
      end else if (e_ga || e_gb) begin
         x = e_ga ? int'(x_a) : int'(x_b);
         y = e_ga ? int'(y_a) : int'(y_b);
         m_last_a = e_ga;
         if (x < COLS && y < ROWS) m_back[y*COLS + x] = e_ga ? val_a : val_b;
         else e_drop = 1'b1;
      end
      m_vb_prev = vblank;
   endfunction

   // one clock: grants checked mid-cycle, registered outputs just after the edge
   task automatic cyc();
      @(negedge clk);
      model_grants();
      obs_ga = gnt_a; obs_gb = gnt_b;
      chk("gnt_a", gnt_a, e_ga);
      chk("gnt_b", gnt_b, e_gb);
      @(posedge clk);
      model_edge();
      #1;
      obs_busy = busy; obs_drop = drop; obs_fd = frame_done;
      chk("busy", busy, m_clear_left > 0);
      chk("drop", drop, e_drop);
      chk("frame_done", frame_done, e_fd);
      chk_fb("framebuffer", framebuffer, m_front);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("rst_gnt_a", gnt_a, 1'b0);
      chk("rst_gnt_b", gnt_b, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drop", drop, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk_fb("rst_framebuffer", framebuffer, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic pulse_vblank();
      vblank = 1'b1; cyc();
      vblank = 1'b0; cyc();
   endtask

   int ka, kb, nbusy, ngnt, nfd;

   initial begin
      model_reset();
      // reset, then a single write that only shows after a commit
      do_reset();
      req_a = 1; x_a = 3; y_a = 2; val_a = 1;
      cyc();
      chk("t1_gnt_same_cycle", obs_ga, 1'b1);
      req_a = 0;
      repeat (3) cyc();
      chk("t1_fb83_before_commit", framebuffer[83], 1'b0);
      vblank = 1; cyc();
      chk("t1_frame_done", obs_fd, 1'b1);
      chk("t1_fb83_after_commit", framebuffer[83], 1'b1);
      vblank = 0; cyc();
      chk("t1_frame_done_once", obs_fd, 1'b0);

      // continuous contention alternates A, B, A, B
      do_reset();
      ka = 0; kb = 0;
      req_a = 1; req_b = 1; val_a = 1; val_b = 1;
      for (int i = 0; i < 8; i++) begin
         x_a = 6'(ka); y_a = 5; x_b = 6'(kb); y_b = 6;
         cyc();
         chk("t2_alternate", obs_ga, (i % 2) == 0);
         if (e_ga) ka++;
         if (e_gb) kb++;
      end
      req_a = 0; req_b = 0;
      pulse_vblank();
      chk("t2_a_set", framebuffer[5*COLS + 3], 1'b1);
      chk("t2_b_set", framebuffer[6*COLS + 3], 1'b1);

      // fill the back buffer, commit, then clear it
      req_a = 1; val_a = 1;
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++) begin
            x_a = 6'(x); y_a = 5'(y);
            cyc();
         end
      req_a = 0;
      pulse_vblank();
      chk_fb("t3_full", framebuffer, {N{1'b1}});
      clear_req = 1; req_a = 1; x_a = 0; y_a = 0; val_a = 0;
      nbusy = 0; ngnt = 0;
      for (int i = 0; i < ROWS + 1; i++) begin
         cyc();
         clear_req = 0;
         nbusy += int'(obs_busy);
         ngnt  += int'(obs_ga);
      end
      chk_int("t3_busy_cycles", nbusy, ROWS);
      chk_int("t3_no_grant_in_clear", ngnt, 0);
      cyc();
      chk("t3_grant_after_clear", obs_ga, 1'b1);
      req_a = 0;
      pulse_vblank();
      chk_fb("t3_cleared", framebuffer, '0);

      // vblank rises mid-clear: commit deferred to the first RUN cycle
      clear_req = 1; req_a = 1; x_a = 7; y_a = 7; val_a = 1;
      cyc();
      clear_req = 0;
      repeat (9) cyc();
      vblank = 1;
      nfd = 0;
      for (int i = 0; i < ROWS - 9; i++) begin
         cyc();
         nfd += int'(obs_fd);
      end
      chk_int("t4_no_commit_in_clear", nfd, 0);
      cyc();
      chk("t4_commit_first_run", obs_fd, 1'b1);
      chk("t4_no_grant_on_commit", obs_ga, 1'b0);
      chk_fb("t4_fb_zero", framebuffer, '0);
      cyc();
      chk("t4_grant_after_commit", obs_ga, 1'b1);
      req_a = 0; vblank = 0;
      cyc();

      // out-of-range writes are granted and dropped
      req_a = 1; x_a = 40; y_a = 0; val_a = 1;
      cyc();
      chk("t5_gnt_x40", obs_ga, 1'b1);
      chk("t5_drop_x40", obs_drop, 1'b1);
      x_a = 5; y_a = 30;
      cyc();
      chk("t5_gnt_y30", obs_ga, 1'b1);
      chk("t5_drop_y30", obs_drop, 1'b1);
      req_a = 0;
      cyc();
      chk("t5_drop_ends", obs_drop, 1'b0);
      pulse_vblank();

      // random traffic
      for (int i = 0; i < 800; i++) begin
         if (!req_a || e_ga) begin
            req_a = ($urandom_range(0, 2) != 0);
            x_a = 6'($urandom_range(0, 41)); y_a = 5'($urandom_range(0, 31));
            val_a = 1'($urandom_range(0, 1));
         end
         if (!req_b || e_gb) begin
            req_b = ($urandom_range(0, 2) != 0);
            x_b = 6'($urandom_range(0, 41)); y_b = 5'($urandom_range(0, 31));
            val_b = 1'($urandom_range(0, 1));
         end
         clear_req = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 24) == 0) vblank = ~vblank;
         cyc();
      end
      req_a = 0; req_b = 0; clear_req = 0; vblank = 0;
      pulse_vblank();

      // reset in the middle of a clear
      clear_req = 1; cyc(); clear_req = 0;
      repeat (15) cyc();
      req_a = 1; x_a = 1; y_a = 1; val_a = 1;
      do_reset();
      req_a = 0; vblank = 1;
      nfd = 0; nbusy = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         nfd += int'(obs_fd);
         nbusy += int'(obs_busy);
      end
      chk_int("t6_no_commit_after_reset", nfd, 0);
      chk_int("t6_run_after_reset", nbusy, 0);
      vblank = 0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
